frac_lutk_cfg: RTL and testbench

FRAC_LUTK_CFG -- requirements
Module: frac_lutk_cfg

---
 rtl/frac_lutk_cfg.sv | 89 ++++++++
 tb/tb_frac_lutk_cfg.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/frac_lutk_cfg.sv
// Fracturable K-input LUT with a serial configuration chain, optional output
// registers and a load-length counter that flags a complete configuration.
module frac_lutk_cfg #(
   parameter int unsigned K = 6
) (
   input  logic         clk,
   input  logic         resetb,
   input  logic [K-1:0] in,
   input  logic         config_en,
   input  logic         ccff_head,
   output logic         ccff_tail,
   output logic         lutk_out,
   output logic [1:0]   lutk1_out,
   output logic         cfg_done
);

   localparam int unsigned NBITS = (1 << K) + 2;
   localparam int unsigned CW    = $clog2(NBITS + 1);
   localparam logic [CW-1:0] CNT_DONE = CW'(NBITS);
   localparam logic [CW-1:0] CNT_MAX  = CW'(NBITS + 1);

   logic [NBITS-1:0] cfg_q, cfg_d;
   logic [CW-1:0]    count_q, count_d;
   logic             config_en_d_q, config_en_d_d;
   logic             done_q, done_d;
   logic [2:0]       out_q, out_d;

   logic [K-1:0]     idx_lo, idx_hi;
   logic             mode, reg_en;
   logic             f0, f1, fk;

   // Lower half of the truth table feeds f0, upper half feeds f1.
   always_comb begin
      idx_lo = {1'b0, in[K-2:0]};
      idx_hi = {1'b1, in[K-2:0]};
      mode   = cfg_q[NBITS-2];
      reg_en = cfg_q[NBITS-1];
      f0     = cfg_q[idx_lo];
      f1     = cfg_q[idx_hi];
      fk     = (mode || in[K-1]) ? f1 : f0;
   end

   always_comb begin
      cfg_d         = cfg_q;
      count_d       = count_q;
      out_d         = out_q;
      config_en_d_d = config_en;
      if (config_en) begin
         cfg_d = {cfg_q[NBITS-2:0], ccff_head};
         if (!config_en_d_q)
            count_d = CW'(1);
         else if (count_q != CNT_MAX)
            count_d = count_q + CW'(1);
      end else begin
         out_d = {fk, f0, f1};
      end
      // Registered from the next count so cfg_done never sees config_en combinationally.
      done_d = (count_d == CNT_DONE);
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         cfg_q         <= '0;
         count_q       <= '0;
         config_en_d_q <= 1'b0;
         done_q        <= 1'b0;
         out_q         <= '0;
      end else begin
         cfg_q         <= cfg_d;
         count_q       <= count_d;
         config_en_d_q <= config_en_d_d;
         done_q        <= done_d;
         out_q         <= out_d;
      end
   end

   always_comb begin
      ccff_tail = cfg_q[NBITS-1];
      cfg_done  = done_q;
      if (reg_en) begin
         lutk_out  = out_q[2];
         lutk1_out = out_q[1:0];
      end else begin
         lutk_out  = fk;
         lutk1_out = {f0, f1};
      end
   end

endmodule

// File: tb/tb_frac_lutk_cfg.sv
// Scoreboarded bench for frac_lutk_cfg: stimulus pushes expectations from a
// bit-history reference model, a negedge monitor pops and compares them.
module tb_frac_lutk_cfg;

   localparam int K = 6;
   localparam int N = (1 << K) + 2;
   localparam int H = 1 << (K - 1);

   logic         clk = 1'b0;
   logic         resetb = 1'b0;
   logic [K-1:0] in_s = '0;
   logic         config_en = 1'b0;
   logic         ccff_head = 1'b0;
   logic         ccff_tail;
   logic         lutk_out;
   logic [1:0]   lutk1_out;
   logic         cfg_done;

   always #5 clk = ~clk;

   frac_lutk_cfg #(.K(K)) dut (
      .clk       (clk),
      .resetb    (resetb),
      .in        (in_s),
      .config_en (config_en),
      .ccff_head (ccff_head),
      .ccff_tail (ccff_tail),
      .lutk_out  (lutk_out),
      .lutk1_out (lutk1_out),
      .cfg_done  (cfg_done)
   );

   typedef struct {
      string    tag;
      bit       lk;
      bit [1:0] l1;
      bit       done;
      bit       tail;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Reference model: hist[i] is the configuration bit presented i shifts ago.
   bit       hist[$];
   int       run_len;
   bit       prev_cen;
   bit [2:0] cap;

   task automatic model_clear();
      hist.delete();
      for (int i = 0; i < N; i++) hist.push_back(1'b0);
      run_len  = 0;
      prev_cen = 1'b0;
      cap      = '0;
   endtask

   task automatic compare(input string tag, input string field,
                          input logic [1:0] act, input logic [1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s at %0t: got %b expected %b", tag, field, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compare(e.tag, "lutk_out",  {1'b0, lutk_out},  {1'b0, e.lk});
         compare(e.tag, "lutk1_out", lutk1_out,         e.l1);
         compare(e.tag, "cfg_done",  {1'b0, cfg_done},  {1'b0, e.done});
         compare(e.tag, "ccff_tail", {1'b0, ccff_tail}, {1'b0, e.tail});
      end
   end

   // One clock of stimulus: drive, predict what the monitor sees, advance the model.
   task automatic step(input bit cen, input bit head, input logic [K-1:0] iv, input string tag);
      int   lo;
      bit   f0, f1, fk, mode, ren;
      exp_t e;
      config_en = cen;
      ccff_head = head;
      in_s      = iv;
      lo   = int'(iv[K-2:0]);
      f0   = hist[lo];
      f1   = hist[H + lo];
      mode = hist[N-2];
      ren  = hist[N-1];
      fk   = mode ? f1 : (iv[K-1] ? f1 : f0);
      e.tag  = tag;
      e.lk   = ren ? cap[2]   : fk;
      e.l1   = ren ? cap[1:0] : {f0, f1};
      e.done = (run_len == N);
      e.tail = hist[N-1];
      exp_q.push_back(e);
      @(posedge clk);
      if (!resetb) begin
         model_clear();
      end else begin
         if (cen) begin
            hist.push_front(head);
            void'(hist.pop_back());
            run_len = prev_cen ? run_len + 1 : 1;
         end else begin
            cap = {fk, f0, f1};
         end
         prev_cen = cen;
      end
      #1;
   endtask

   task automatic do_reset(input string tag);
      resetb = 1'b0;
      model_clear();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, K'($urandom), tag);
      resetb = 1'b1;
   endtask

   // Presents reg_en, mode, then truth[2^K-1] down to truth[0], after `pre` filler bits.
   task automatic load(input logic [63:0] truth, input bit mode, input bit ren,
                       input int pre, input string tag);
      bit seq[$];
      for (int i = 0; i < pre; i++) seq.push_back(1'($urandom));
      seq.push_back(ren);
      seq.push_back(mode);
      for (int i = (1 << K) - 1; i >= 0; i--) seq.push_back(truth[i]);
      foreach (seq[i]) step(1'b1, seq[i], K'($urandom), tag);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [63:0] t;
      logic [K-1:0] iv;
      model_clear();
      #1;
      do_reset("reset");
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, K'($urandom), "reset_idle");

      // AND6: only truth[63] set.
      t = '0;
      t[63] = 1'b1;
      load(t, 1'b0, 1'b0, 0, "and6_load");
      for (int i = 0; i < 64; i++) step(1'b0, 1'b0, K'(i), "and6_sweep");

      // Fracture in mode 1.
      t = 64'hAAAA_AAAA_5555_5555;
      load(t, 1'b1, 1'b0, 0, "frac_load");
      for (int i = 0; i < 64; i++) step(1'b0, 1'b0, K'(i), "frac_sweep");

      // Registered XOR table, then a 3-cycle config_en hold.
      for (int i = 0; i < 64; i++) begin
         iv   = K'(i);
         t[i] = ^iv;
      end
      load(t, 1'b0, 1'b1, 0, "xor_load");
      for (int i = 0; i < 24; i++) step(1'b0, 1'b0, K'($urandom), "xor_reg");
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, K'($urandom), "xor_freeze");
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, K'($urandom), "xor_after");

      // 67-bit over-shift: done pulses for one cycle, tail tracks history.
      do_reset("chain_reset");
      load({$urandom, $urandom}, 1'($urandom), 1'b0, 1, "chain_load67");
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, K'($urandom), "chain_idle");

      // Reset after 30 shifts, then a fresh full load.
      for (int i = 0; i < 30; i++) step(1'b1, 1'($urandom), K'($urandom), "mid_shift");
      do_reset("mid_reset");
      for (int i = 0; i < 2; i++) step(1'b0, 1'b0, K'($urandom), "mid_idle");
      load(64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 0, "mid_reload");
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, K'($urandom), "mid_use");

      // Random configurations interleaved with random use, including gaps in loading.
      for (int r = 0; r < 6; r++) begin
         load({$urandom, $urandom}, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), "rnd_load");
         for (int i = 0; i < 20; i++)
            step(($urandom_range(0, 7) == 0), 1'($urandom), K'($urandom), "rnd_use");
      end

      step(1'b0, 1'b0, '0, "final");
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
